// File: rtl/lc3_mem_master.sv
// CPU-side memory-access initiator for the LC3 core: independent fetch and data
// channels, each driving its own memory handshake with a per-channel abort timer.
module lc3_mem_master #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    // core fetch side
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [15:0] fetch_instr,
    // core data side
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ready,
    output logic        data_valid,
    output logic [15:0] data_rdata,
    output logic [1:0]  err_timeout,
    // instruction memory
    output logic [15:0] pc,
    output logic        instrmem_rd,
    input  logic [15:0] Instr_dout,
    input  logic        complete_instr,
    // data memory
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_rd,
    input  logic [15:0] Data_dout,
    input  logic        complete_data,
    // debug: {data channel waiting, fetch channel waiting}
    output logic [1:0]  dbg_state
);

    // Handshake: a req is taken on any edge where the matching ready is high;
    // the channel then waits for complete_* (or the timer) and answers with a
    // one-cycle valid pulse, by which time ready is already high again.

    typedef enum logic { F_IDLE = 1'b0, F_WAIT = 1'b1 } f_state_t;
    typedef enum logic { D_IDLE = 1'b0, D_WAIT = 1'b1 } d_state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    f_state_t    f_state_q, f_state_d;
    logic [7:0]  f_cnt_q, f_cnt_d;
    logic [15:0] pc_q, pc_d;
    logic        rd_q, rd_d;
    logic        f_valid_q, f_valid_d;
    logic [15:0] f_instr_q, f_instr_d;
    logic        f_err_q, f_err_d;

    d_state_t    d_state_q, d_state_d;
    logic [7:0]  d_cnt_q, d_cnt_d;
    logic [15:0] daddr_q, daddr_d;
    logic [15:0] ddin_q, ddin_d;
    logic        drd_q, drd_d;
    logic        d_valid_q, d_valid_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state_q <= F_IDLE;
            f_cnt_q   <= 8'd0;
            pc_q      <= RESET_PC;
            rd_q      <= 1'b0;
            f_valid_q <= 1'b0;
            f_instr_q <= 16'd0;
            f_err_q   <= 1'b0;
            d_state_q <= D_IDLE;
            d_cnt_q   <= 8'd0;
            daddr_q   <= 16'd0;
            ddin_q    <= 16'd0;
            drd_q     <= 1'b1;
            d_valid_q <= 1'b0;
            d_rdata_q <= 16'd0;
            d_err_q   <= 1'b0;
        end else begin
            f_state_q <= f_state_d;
            f_cnt_q   <= f_cnt_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            f_valid_q <= f_valid_d;
            f_instr_q <= f_instr_d;
            f_err_q   <= f_err_d;
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            daddr_q   <= daddr_d;
            ddin_q    <= ddin_d;
            drd_q     <= drd_d;
            d_valid_q <= d_valid_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    // Fetch channel; completion is checked before the timer so it wins a tie.
    always_comb begin
        f_state_d = f_state_q;
        f_cnt_d   = f_cnt_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        f_valid_d = 1'b0;
        f_instr_d = f_instr_q;
        f_err_d   = f_err_q;
        case (f_state_q)
            F_IDLE: begin
                if (fetch_req) begin
                    pc_d      = fetch_addr;
                    rd_d      = 1'b1;
                    f_cnt_d   = 8'd0;
                    f_state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (complete_instr) begin
                    f_instr_d = Instr_dout;
                    rd_d      = 1'b0;
                    f_valid_d = 1'b1;
                    f_state_d = F_IDLE;
                end else if (f_cnt_q == TMO_LAST) begin
                    rd_d      = 1'b0;
                    f_valid_d = 1'b1;
                    f_err_d   = 1'b1;
                    f_state_d = F_IDLE;
                end else begin
                    f_cnt_d = f_cnt_q + 8'd1;
                end
            end
            default: f_state_d = F_IDLE;
        endcase
    end

    // Data channel; Data_rd doubles as the load/store marker while waiting.
    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        daddr_d   = daddr_q;
        ddin_d    = ddin_q;
        drd_d     = drd_q;
        d_valid_d = 1'b0;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        case (d_state_q)
            D_IDLE: begin
                if (data_req) begin
                    daddr_d   = data_addr;
                    ddin_d    = data_wdata;
                    drd_d     = ~data_we;
                    d_cnt_d   = 8'd0;
                    d_state_d = D_WAIT;
                end
            end
            D_WAIT: begin
                if (complete_data) begin
                    if (drd_q) d_rdata_d = Data_dout;
                    drd_d     = 1'b1;
                    d_valid_d = 1'b1;
                    d_state_d = D_IDLE;
                end else if (d_cnt_q == TMO_LAST) begin
                    drd_d     = 1'b1;
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b1;
                    d_state_d = D_IDLE;
                end else begin
                    d_cnt_d = d_cnt_q + 8'd1;
                end
            end
            default: d_state_d = D_IDLE;
        endcase
    end

    assign fetch_ready = (f_state_q == F_IDLE);
    assign fetch_valid = f_valid_q;
    assign fetch_instr = f_instr_q;
    assign pc          = pc_q;
    assign instrmem_rd = rd_q;
    assign data_ready  = (d_state_q == D_IDLE);
    assign data_valid  = d_valid_q;
    assign data_rdata  = d_rdata_q;
    assign Data_addr   = daddr_q;
    assign Data_din    = ddin_q;
    assign Data_rd     = drd_q;
    assign err_timeout = {d_err_q, f_err_q};
    assign dbg_state   = {d_state_q == D_WAIT, f_state_q == F_WAIT};

endmodule

// File: tb/tb_lc3_mem_master.sv
// Directed bench for lc3_mem_master: reset, fetch, store/load, concurrency,
// timeout and reset-abort, each step checked against hand-computed values.
module tb_lc3_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ready, fetch_valid;
    logic [15:0] fetch_instr;
    logic        data_req, data_we;
    logic [15:0] data_addr, data_wdata;
    logic        data_ready, data_valid;
    logic [15:0] data_rdata;
    logic [1:0]  err_timeout;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic [15:0] Data_addr, Data_din;
    logic        Data_rd;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_mem_master #(.RESET_PC(16'h3000), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ready(data_ready), .data_valid(data_valid), .data_rdata(data_rdata),
        .err_timeout(err_timeout),
        .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd),
        .Data_dout(Data_dout), .complete_data(complete_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = 16'h0;
        data_req = 1'b0; data_we = 1'b0; data_addr = 16'h0; data_wdata = 16'h0;
        Instr_dout = 16'h0; complete_instr = 1'b0;
        Data_dout = 16'h0; complete_data = 1'b0;

        // reset
        tick(); tick();
        check("rst_pc", pc, 16'h3000);
        check("rst_instrmem_rd", instrmem_rd, 1'b0);
        check("rst_Data_rd", Data_rd, 1'b1);
        check("rst_fetch_ready", fetch_ready, 1'b1);
        check("rst_data_ready", data_ready, 1'b1);
        check("rst_err", err_timeout, 2'b00);
        check("rst_fetch_valid", fetch_valid, 1'b0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_fetch_instr", fetch_instr, 16'h0);
        check("rst_data_rdata", data_rdata, 16'h0);
        check("rst_Data_addr", Data_addr, 16'h0);
        check("rst_Data_din", Data_din, 16'h0);
        reset = 1'b0;
        tick();

        // single fetch, completion two cycles after the request edge
        fetch_req = 1'b1; fetch_addr = 16'h3000;
        tick();
        fetch_req = 1'b0; fetch_addr = 16'h7777;
        check("f1_rd_c1", instrmem_rd, 1'b1);
        check("f1_pc", pc, 16'h3000);
        check("f1_ready_low", fetch_ready, 1'b0);
        tick();
        check("f1_rd_c2", instrmem_rd, 1'b1);
        check("f1_pc_hold", pc, 16'h3000);
        check("f1_no_valid", fetch_valid, 1'b0);
        complete_instr = 1'b1; Instr_dout = 16'h1021;
        tick();
        complete_instr = 1'b0; Instr_dout = 16'h0;
        check("f1_rd_drop", instrmem_rd, 1'b0);
        check("f1_valid", fetch_valid, 1'b1);
        check("f1_instr", fetch_instr, 16'h1021);
        check("f1_ready_back", fetch_ready, 1'b1);
        // stale completion while idle must be discarded
        complete_instr = 1'b1; Instr_dout = 16'hFFFF;
        tick();
        complete_instr = 1'b0;
        check("f1_valid_one_cycle", fetch_valid, 1'b0);
        check("stale_instr_kept", fetch_instr, 16'h1021);
        tick();
        check("stale_no_valid", fetch_valid, 1'b0);
        check("stale_rd_low", instrmem_rd, 1'b0);

        // store then back-to-back load
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h4000; data_wdata = 16'hBEEF;
        tick();
        data_req = 1'b0; data_addr = 16'h1234; data_wdata = 16'h0;
        check("st_Data_rd", Data_rd, 1'b0);
        check("st_Data_addr", Data_addr, 16'h4000);
        check("st_Data_din", Data_din, 16'hBEEF);
        check("st_ready_low", data_ready, 1'b0);
        tick();
        check("st_addr_hold", Data_addr, 16'h4000);
        check("st_rd_hold", Data_rd, 1'b0);
        complete_data = 1'b1; Data_dout = 16'h5555;
        tick();
        complete_data = 1'b0;
        check("st_valid", data_valid, 1'b1);
        check("st_Data_rd_back", Data_rd, 1'b1);
        check("st_rdata_unchanged", data_rdata, 16'h0);
        check("st_ready_back", data_ready, 1'b1);
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h4000;
        tick();
        data_req = 1'b0;
        check("ld_Data_rd", Data_rd, 1'b1);
        check("ld_Data_addr", Data_addr, 16'h4000);
        check("ld_valid_low", data_valid, 1'b0);
        check("ld_ready_low", data_ready, 1'b0);
        complete_data = 1'b1; Data_dout = 16'hBEEF;
        tick();
        complete_data = 1'b0; Data_dout = 16'h0;
        check("ld_valid", data_valid, 1'b1);
        check("ld_rdata", data_rdata, 16'hBEEF);
        tick();
        check("ld_valid_one_cycle", data_valid, 1'b0);

        // concurrent fetch and load accepted on the same edge
        fetch_req = 1'b1; fetch_addr = 16'h3001;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h5000;
        tick();
        fetch_req = 1'b0; data_req = 1'b0;
        check("cc_pc", pc, 16'h3001);
        check("cc_rd", instrmem_rd, 1'b1);
        check("cc_Data_addr", Data_addr, 16'h5000);
        check("cc_dbg_both_wait", dbg_state, 2'b11);
        complete_instr = 1'b1; Instr_dout = 16'h2402;
        tick();
        complete_instr = 1'b0;
        check("cc_fetch_valid", fetch_valid, 1'b1);
        check("cc_fetch_instr", fetch_instr, 16'h2402);
        check("cc_data_still_wait", data_ready, 1'b0);
        check("cc_data_no_valid", data_valid, 1'b0);
        tick();
        check("cc_Data_addr_hold", Data_addr, 16'h5000);
        complete_data = 1'b1; Data_dout = 16'hA5A5;
        tick();
        complete_data = 1'b0;
        check("cc_data_valid", data_valid, 1'b1);
        check("cc_data_rdata", data_rdata, 16'hA5A5);
        check("cc_fetch_quiet", fetch_valid, 1'b0);

        // completion on the last wait cycle wins over the timeout
        fetch_req = 1'b1; fetch_addr = 16'h3002;
        tick();
        fetch_req = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        check("edge_rd_still_high", instrmem_rd, 1'b1);
        complete_instr = 1'b1; Instr_dout = 16'h0E0E;
        tick();
        complete_instr = 1'b0;
        check("edge_valid", fetch_valid, 1'b1);
        check("edge_instr", fetch_instr, 16'h0E0E);
        check("edge_no_err", err_timeout, 2'b00);

        // fetch timeout at the top of the address range
        fetch_req = 1'b1; fetch_addr = 16'hFFFF;
        tick();
        fetch_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("tmo_rd_wait", instrmem_rd, 1'b1);
            check("tmo_no_early_valid", fetch_valid, 1'b0);
        end
        tick();
        check("tmo_rd_drop", instrmem_rd, 1'b0);
        check("tmo_valid", fetch_valid, 1'b1);
        check("tmo_instr_unchanged", fetch_instr, 16'h0E0E);
        check("tmo_err", err_timeout, 2'b01);
        check("tmo_pc", pc, 16'hFFFF);
        tick();
        check("tmo_err_sticky", err_timeout, 2'b01);
        check("tmo_valid_one_cycle", fetch_valid, 1'b0);

        // data timeout on a store
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h6000; data_wdata = 16'h1111;
        tick();
        data_req = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        check("dtmo_rd_low_wait", Data_rd, 1'b0);
        tick();
        check("dtmo_Data_rd", Data_rd, 1'b1);
        check("dtmo_valid", data_valid, 1'b1);
        check("dtmo_rdata_unchanged", data_rdata, 16'hA5A5);
        check("dtmo_err", err_timeout, 2'b11);

        // reset while a store is outstanding
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h7000; data_wdata = 16'h2222;
        tick();
        data_req = 1'b0;
        check("rm_Data_rd_low", Data_rd, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_Data_rd", Data_rd, 1'b1);
        check("rm_no_valid", data_valid, 1'b0);
        check("rm_ready", data_ready, 1'b1);
        check("rm_err_cleared", err_timeout, 2'b00);
        complete_data = 1'b1; Data_dout = 16'h9999;
        tick();
        complete_data = 1'b0;
        check("rm_no_late_valid", data_valid, 1'b0);
        check("rm_rdata_reset", data_rdata, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
